// File: rtl/fir_dec_fifo.sv
// fir_dec_fifo: post-FIR stage. Drops the start-up transient, decimates by R,
// and buffers kept samples in a show-ahead FIFO with a valid/ready read port.
// A kept sample that finds the FIFO full (with no read) is lost and latches a
// sticky overflow flag.
module fir_dec_fifo #(
    parameter int W      = 8,
    parameter int R      = 4,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W-1:0]           x_in,
    input  logic                   x_valid,
    output logic [W-1:0]           y_out,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int AW   = $clog2(DEPTH);
    localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int PH_W = (R < 2) ? 1 : $clog2(R);

    logic [WC_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic            overflow_q, overflow_d;
    logic [W-1:0]    mem_q [DEPTH];

    logic warm_done, post, keep, full, rd, wr, drop;

    // Qualify the incoming sample: warm-up done, decimation phase, FIFO handshake.
    always_comb begin
        warm_done = (warm_cnt_q == WC_W'(WARMUP));
        post      = x_valid && warm_done;
        keep      = post && (phase_q == '0);
        full      = (fill_q == (AW+1)'(DEPTH));
        rd        = (fill_q != '0) && y_ready;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        wr        = keep && (!full || rd);
        drop      = keep && full && !rd;
    end

    // Next-state for counters, pointers, occupancy and the sticky overflow flag.
    always_comb begin
        warm_cnt_d = warm_cnt_q;
        if (x_valid && !warm_done) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
        end

        // Phase advances on every post-warm-up sample, including dropped ones,
        // so the decimation grid never slips.
        phase_d = phase_q;
        if (post) begin
            phase_d = (phase_q == PH_W'(R - 1)) ? '0 : phase_q + 1'b1;
        end

        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

        fill_d = fill_q;
        if (wr && !rd) begin
            fill_d = fill_q + 1'b1;
        end else if (rd && !wr) begin
            fill_d = fill_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state register, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt_q <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= x_in;
        end
    end

    // Show-ahead read port: head entry driven straight from storage, zero when empty.
    always_comb begin
        y_valid  = (fill_q != '0);
        y_out    = y_valid ? mem_q[rd_ptr_q] : '0;
        fill     = fill_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_fir_dec_fifo.sv
// Testbench for fir_dec_fifo: three parameterisations driven in parallel,
// directed table/sequence checks plus randomized traffic against a queue model.
module tb_fir_dec_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] x_in;
    logic       x_valid, y_ready, ovf_clr;
    logic [7:0] yo [3];
    logic       yv [3];
    logic [3:0] fl [3];
    logic       ov [3];

    fir_dec_fifo #(.W(8), .R(4), .DEPTH(8), .WARMUP(5)) u_a (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(yo[0]), .y_valid(yv[0]), .y_ready(y_ready),
        .fill(fl[0]), .overflow(ov[0]), .ovf_clr(ovf_clr));
    fir_dec_fifo #(.W(8), .R(1), .DEPTH(8), .WARMUP(0)) u_b (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(yo[1]), .y_valid(yv[1]), .y_ready(y_ready),
        .fill(fl[1]), .overflow(ov[1]), .ovf_clr(ovf_clr));
    fir_dec_fifo #(.W(8), .R(2), .DEPTH(8), .WARMUP(0)) u_c (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .y_out(yo[2]), .y_valid(yv[2]), .y_ready(y_ready),
        .fill(fl[2]), .overflow(ov[2]), .ovf_clr(ovf_clr));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: per instance, count of accepted samples since reset,
    // a queue of buffered samples, and the sticky overflow bit.
    int p_r [3] = '{4, 1, 2};
    int p_w [3] = '{5, 0, 0};
    int mq [3][$];
    int seen [3];
    bit movf [3];

    typedef struct {
        logic [7:0] x;
        logic       v;
        logic [7:0] y;
    } vec_t;
    vec_t tv [21];
    int exp1 [21] = '{0,0,0,0,0,5,0,0,0,9,0,0,0,13,0,0,0,17,0,0,0};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            seen[k] = 0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int sz;
            bit rdk, keep, drop;
            sz   = mq[k].size();
            rdk  = (sz > 0) && y_ready;
            keep = 1'b0;
            if (x_valid) begin
                if (seen[k] >= p_w[k] && ((seen[k] - p_w[k]) % p_r[k]) == 0) keep = 1'b1;
                seen[k]++;
            end
            drop = keep && (sz == 8) && !rdk;
            if (rdk) void'(mq[k].pop_front());
            if (keep && !drop) mq[k].push_back(int'(x_in));
            if (drop) movf[k] = 1'b1;
            else if (ovf_clr) movf[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = mq[k].size();
            chk($sformatf("u%0d.y_valid", k), 32'(yv[k]), 32'(sz > 0));
            chk($sformatf("u%0d.y_out", k), 32'(yo[k]), (sz > 0) ? mq[k][0] : 0);
            chk($sformatf("u%0d.fill", k), 32'(fl[k]), sz);
            chk($sformatf("u%0d.overflow", k), 32'(ov[k]), 32'(movf[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Called between edges; asserts reset, checks the async clear, releases.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        reset = 1'b0;
    endtask

    int vals5 [4] = '{-3, -2, -1, 0};
    int bias;

    initial begin
        for (int i = 0; i < 21; i++) begin
            tv[i].x = 8'(i);
            tv[i].v = (exp1[i] != 0);
            tv[i].y = 8'(exp1[i]);
        end
        reset = 1'b0; x_in = '0; x_valid = 1'b0; y_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        do_reset();

        // 1) warm-up and decimate by 4
        x_valid = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            x_in = tv[i].x;
            cycle();
            chk($sformatf("t1.y_valid[%0d]", i), 32'(yv[0]), 32'(tv[i].v));
            chk($sformatf("t1.y_out[%0d]", i), 32'(yo[0]), 32'(tv[i].y));
        end

        // 2) fill to full, no reads
        do_reset();
        y_ready = 1'b0; x_valid = 1'b1;
        for (int v = 1; v <= 8; v++) begin x_in = 8'(v); cycle(); end
        chk("t2.fill", 32'(fl[1]), 8);
        chk("t2.y_out", 32'(yo[1]), 1);
        chk("t2.overflow", 32'(ov[1]), 0);

        // 3) overflow, drain, clear
        x_in = 8'd9; cycle();
        chk("t3.overflow", 32'(ov[1]), 1);
        chk("t3.fill", 32'(fl[1]), 8);
        x_valid = 1'b0; y_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            chk($sformatf("t3.drain[%0d]", v), 32'(yo[1]), v);
            cycle();
        end
        chk("t3.empty", 32'(yv[1]), 0);
        chk("t3.sticky", 32'(ov[1]), 1);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("t3.cleared", 32'(ov[1]), 0);

        // 4) simultaneous read+write at full, pointer wrap
        do_reset();
        y_ready = 1'b0; x_valid = 1'b1;
        for (int v = 1; v <= 8; v++) begin x_in = 8'(v); cycle(); end
        y_ready = 1'b1; x_in = 8'd9; cycle();
        chk("t4.fill", 32'(fl[1]), 8);
        chk("t4.overflow", 32'(ov[1]), 0);
        x_valid = 1'b0;
        for (int v = 2; v <= 9; v++) begin
            chk($sformatf("t4.drain[%0d]", v), 32'(yo[1]), v);
            cycle();
        end
        chk("t4.fill_end", 32'(fl[1]), 0);

        // 5) x_valid gaps, R=2, signed data
        do_reset();
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1; x_in = 8'(vals5[i]); cycle();
            x_valid = 1'b0; cycle();
        end
        chk("t5.fill", 32'(fl[2]), 2);
        chk("t5.head0", 32'(yo[2]), 32'h0000_00FD);
        y_ready = 1'b1; cycle();
        chk("t5.head1", 32'(yo[2]), 32'h0000_00FF);
        cycle();
        chk("t5.empty", 32'(yv[2]), 0);

        // 6) asynchronous reset mid-stream, then warm-up restarts
        do_reset();
        y_ready = 1'b0; x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin x_in = 8'(40 + i); cycle(); end
        chk("t6.fill_pre", 32'(fl[1]), 3);
        reset = 1'b1;
        #1;
        chk("t6.fill_rst", 32'(fl[1]), 0);
        chk("t6.valid_rst", 32'(yv[1]), 0);
        chk("t6.yout_rst", 32'(yo[1]), 0);
        model_reset();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin x_in = 8'(60 + i); cycle(); end
        chk("t6.warm_fill", 32'(fl[0]), 0);
        x_in = 8'd65; cycle();
        chk("t6.first_kept_fill", 32'(fl[0]), 1);
        chk("t6.first_kept_out", 32'(yo[0]), 65);

        // Randomized traffic with varying consumer throughput
        bias = 1;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) bias = $urandom_range(0, 4);
            if ($urandom_range(0, 199) == 0) do_reset();
            x_valid = ($urandom_range(0, 3) != 0);
            x_in    = 8'($urandom);
            y_ready = ($urandom_range(0, 4) < bias);
            ovf_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
